pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
  clk  in  1  sole clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  16  fetch address (current PC)
  imem_rdy  in  1  memory returns instr_in this cycle
  instr_in  in  16  fetched instruction word
  instr_out  out  16  latched instruction to decode
  instr_valid  out  1  instr_out valid (one EXEC cycle)
  stall  in  1  hold EXEC, no PC/flag update
  flag_wr  in  3  per-bit flag write enable {V,Z,N}
  flag_in  in  3  new flag values {V,Z,N}
  branch  in  1  EXEC instruction is B (PC-relative conditional)
  br  in  1  EXEC instruction is BR (register conditional)
  cond  in  3  condition code
  imm  in  9  signed word offset for B
  reg_target  in  16  target for BR
  halt  in  1  EXEC instruction is HLT
  pc_out  out  16  architectural PC
  flags  out  3  {V,Z,N} register
  halted  out  1  sequencer stopped

Function
REQ-002 FSM states SHALL be RESET, FETCH, EXEC and HALTED; the encoding SHALL be taken from the shared package.
REQ-003 RESET SHALL last exactly one cycle after rst deasserts, then move to FETCH.
REQ-004 FETCH SHALL drive imem_req=1 and imem_addr=pc_out, and SHALL hold until imem_rdy=1.
REQ-005 On imem_rdy=1, instr_in SHALL be registered into instr_out and the FSM SHALL enter EXEC; fetch latency is therefore 1 cycle beyond the imem_rdy cycle.
REQ-006 instr_valid SHALL be 1 only in EXEC; imem_req SHALL be 0 outside FETCH.
REQ-007 When EXEC is active with stall=0, the sequencer SHALL commit PC, commit flags, and return to FETCH, or enter HALTED if halt=1.
REQ-008 When EXEC is active with stall=1, the sequencer SHALL remain in EXEC with instr_out, pc_out and flags unchanged.
REQ-009 next PC SHALL equal: halt ? pc_out : taken ? target : pc_out+2.
  - B target = pc_out+2 + (sign_extend(imm)<<1).
  - BR target = reg_target.
  - All adds are modulo 2^16.
REQ-010 taken SHALL use the flags value held before this EXEC's flag write. Codes {V,Z,N}:
  - 000 !Z
  - 001 Z
  - 010 !Z&!N
  - 011 N
  - 100 Z|(!Z&!N)
  - 101 N|Z
  - 110 V
  - 111 always
REQ-011 If branch and br are both 1, branch SHALL win; if neither is 1, taken SHALL be 0.
REQ-012 Each flags bit SHALL update from flag_in only where the corresponding flag_wr bit is 1, and only on a committing EXEC.
REQ-013 If halt=1 together with branch, br or flag_wr, halt SHALL win: the PC SHALL be held and flags SHALL still update.
REQ-014 HALTED SHALL be absorbing until rst; in HALTED, halted=1 and imem_req=0.
REQ-015 PC wrap-around SHALL be silent: 0xFFFE+2 = 0x0000.

Reset
REQ-016 On rst=1 the sequencer SHALL set pc_out=0x0000, flags=000, instr_out=0x0000, instr_valid=0, imem_req=0, halted=0, state=RESET.
REQ-017 rst asserted in any state, including mid-FETCH or while stalled, SHALL abandon the operation in progress without committing.

Configuration
REQ-018 Macro PC_SEQ_BR_EN SHALL control BR support.
  - Defined: br and reg_target SHALL be honoured.
  - Undefined: br SHALL be ignored, so taken depends on branch only, and reg_target SHALL be unused.

Structure
REQ-019 The shared package SHALL hold:
  - state typedef
  - condition-code constants (COND_NE..COND_UNC)
  - flag bit indices (FLAG_N=0, FLAG_Z=1, FLAG_V=2)
  - reset PC constant 16'h0000
REQ-020 Sub-module cond_eval (inputs flags and cond, output taken_cond) SHALL hold the condition logic; the adders SHALL be inline.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Reset: rst 2 cycles -> pc_out=0, flags=000; imem_req rises 2 cycles after rst falls.
  - Sequential fetch: imem_rdy held 1, no branches -> pc_out 0,2,4,6; instr_valid pulses every 2nd cycle.
  - Branch: flags Z=1, B cond=001, imm=9'h1FE at pc=0x0010 -> next pc=0x000E; same with Z=0 -> 0x0012.
  - Stall and wait: stall high 3 EXEC cycles -> pc and flags frozen; imem_rdy delayed 4 cycles -> imem_addr stable throughout.
  - Flag update: flag_wr=010, flag_in=111 with B cond=001 from flags=000 -> not taken, flags become 010.
  - Halt: halt with flag_wr=001 -> pc held, flags[N] updated, halted=1 forever; rst mid-HALTED -> pc=0 and refetch.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, condition codes,
// flag bit positions and the reset PC.
package pc_sequencer_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_VS  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;

    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the memory (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rdy;
    logic [15:0]     instr_in;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  instr_in
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output instr_in
    );

endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// Branch condition evaluation over the {V,Z,N} flag register.
module cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken_cond
);

    logic flag_n;
    logic flag_z;
    logic flag_v;

    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_v = flags[FLAG_V];

    always_comb begin
        taken_cond = 1'b0;
        case (cond)
            COND_NE:  taken_cond = !flag_z;
            COND_EQ:  taken_cond = flag_z;
            COND_GT:  taken_cond = !flag_z && !flag_n;
            COND_LT:  taken_cond = flag_n;
            COND_GE:  taken_cond = flag_z || (!flag_z && !flag_n);
            COND_LE:  taken_cond = flag_n || flag_z;
            COND_VS:  taken_cond = flag_v;
            COND_UNC: taken_cond = 1'b1;
            default:  taken_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute program-counter sequencer with conditional branches, flags and halt.
// Define PC_SEQ_BR_EN to honour br/reg_target (register-indirect branches).
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pc_sequencer_if.master      imem,
    output logic [15:0]         instr_out,
    output logic                instr_valid,
    input  logic                stall,
    input  logic [2:0]          flag_wr,
    input  logic [2:0]          flag_in,
    input  logic                branch,
    input  logic                br,
    input  logic [2:0]          cond,
    input  logic [8:0]          imm,
    input  logic [PC_W-1:0]     reg_target,
    input  logic                halt,
    output logic [PC_W-1:0]     pc_out,
    output logic [2:0]          flags,
    output logic                halted
);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [2:0]      flags_reg, flags_next;
    logic [15:0]     instr_reg, instr_next;
    // Keeps RESET occupied for one full cycle after rst is first sampled low.
    logic            reset_hold_reg;

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] b_target;
    logic [PC_W-1:0] target;
    logic            taken_cond;
    logic            taken;

    cond_eval u_cond_eval (
        .flags      (flags_reg),
        .cond       (cond),
        .taken_cond (taken_cond)
    );

    assign seq_pc   = pc_reg + 16'd2;
    assign b_target = seq_pc + {{6{imm[8]}}, imm, 1'b0};

`ifdef PC_SEQ_BR_EN
    assign taken  = (branch | br) & taken_cond;
    assign target = branch ? b_target : reg_target;
`else
    assign taken  = branch & taken_cond;
    assign target = b_target;
    logic unused_br;
    assign unused_br = ^{br, reg_target};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RESET;
            pc_reg         <= RESET_PC;
            flags_reg      <= 3'b000;
            instr_reg      <= 16'h0000;
            reset_hold_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            flags_reg      <= flags_next;
            instr_reg      <= instr_next;
            reset_hold_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        flags_next = flags_reg;
        instr_next = instr_reg;
        case (state_reg)
            ST_RESET: begin
                if (!reset_hold_reg) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_rdy) begin
                    instr_next = imem.instr_in;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Condition is judged on flags_reg, i.e. before this commit's flag write.
                if (!stall) begin
                    pc_next    = halt ? pc_reg : (taken ? target : seq_pc);
                    flags_next = (flags_reg & ~flag_wr) | (flag_in & flag_wr);
                    state_next = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: state_next = ST_RESET;
        endcase
    end

    assign imem.imem_req  = (state_reg == ST_FETCH);
    assign imem.imem_addr = pc_reg;
    assign instr_out      = instr_reg;
    assign instr_valid    = (state_reg == ST_EXEC);
    assign pc_out         = pc_reg;
    assign flags          = flags_reg;
    assign halted         = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; inputs driven and outputs sampled on negedge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic [2:0]  flag_wr;
    logic [2:0]  flag_in;
    logic        branch;
    logic        br;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [15:0] reg_target;
    logic        halt;
    logic [15:0] pc_out;
    logic [2:0]  flags;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_pc;

    pc_sequencer_if imem_bus ();

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .stall       (stall),
        .flag_wr     (flag_wr),
        .flag_in     (flag_in),
        .branch      (branch),
        .br          (br),
        .cond        (cond),
        .imm         (imm),
        .reg_target  (reg_target),
        .halt        (halt),
        .pc_out      (pc_out),
        .flags       (flags),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_exec();
        stall = 0; flag_wr = 0; flag_in = 0; branch = 0; br = 0;
        cond = 0; imm = 0; reg_target = 0; halt = 0;
    endtask

    // Precondition: in FETCH at a negedge. Afterwards in EXEC.
    task automatic do_fetch(input logic [15:0] word);
        imem_bus.imem_rdy = 1; imem_bus.instr_in = word;
        tick();
        imem_bus.imem_rdy = 0; imem_bus.instr_in = 16'h0000;
    endtask

    // Precondition: in EXEC at a negedge. Commits one instruction.
    task automatic do_exec(input logic b, input logic r, input logic [2:0] c, input logic [8:0] im,
                           input logic [15:0] rt, input logic [2:0] fw, input logic [2:0] fi, input logic h);
        branch = b; br = r; cond = c; imm = im; reg_target = rt; flag_wr = fw; flag_in = fi; halt = h;
        tick();
        $display("exec b=%0b br=%0b cond=%03b imm=%03h halt=%0b -> pc_out=%04h flags=%03b halted=%0b",
                 b, r, c, im, h, pc_out, flags, halted);
        clear_exec();
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick();
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc_out); end
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", flags); end
        checks++; if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl req=%b valid=%b halted=%b want 0 0 0", imem_bus.imem_req, instr_valid, halted); end
        checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr_out); end
        rst = 0; tick();
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_1cyc got %b want 0", imem_bus.imem_req); end
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_req_2cyc req=%b addr=%h want 1 0000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'(2 * i) || instr_valid !== 1'b0) begin
                errors++; $display("FAIL seq_fetch%0d req=%b addr=%h valid=%b want 1 %h 0", i, imem_bus.imem_req, imem_bus.imem_addr, instr_valid, 16'(2 * i)); end
            do_fetch(16'hA000 + 16'(i));
            checks++; if (instr_valid !== 1'b1 || instr_out !== 16'hA000 + 16'(i) || pc_out !== 16'(2 * i)) begin
                errors++; $display("FAIL seq_exec%0d valid=%b instr=%h pc=%h want 1 %h %h", i, instr_valid, instr_out, pc_out, 16'hA000 + 16'(i), 16'(2 * i)); end
            do_exec(0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0, 0);
        end
        checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL seq_end_pc got %h want 0008", pc_out); end
    endtask

    task automatic test_branch();
        do_fetch(16'hB000);
        do_exec(1, 0, COND_UNC, 9'd3, 16'd0, 3'b010, 3'b010, 0);
        checks++; if (pc_out !== 16'h0010 || flags !== 3'b010) begin
            errors++; $display("FAIL br_setup pc=%h flags=%b want 0010 010", pc_out, flags); end
        do_fetch(16'hB001);
        do_exec(1, 0, COND_EQ, 9'h1FE, 16'd0, 3'b000, 3'b000, 0);
        checks++; if (pc_out !== 16'h000E) begin errors++; $display("FAIL br_taken got %h want 000E", pc_out); end
        do_fetch(16'hB002);
        do_exec(1, 0, COND_UNC, 9'd0, 16'd0, 3'b010, 3'b000, 0);
        checks++; if (pc_out !== 16'h0010 || flags !== 3'b000) begin
            errors++; $display("FAIL br_setup2 pc=%h flags=%b want 0010 000", pc_out, flags); end
        do_fetch(16'hB003);
        do_exec(1, 0, COND_EQ, 9'h1FE, 16'd0, 3'b000, 3'b000, 0);
        checks++; if (pc_out !== 16'h0012) begin errors++; $display("FAIL br_not_taken got %h want 0012", pc_out); end
    endtask

    task automatic test_br();
        do_fetch(16'hC000);
        do_exec(0, 1, COND_UNC, 9'd0, 16'h0100, 3'b000, 3'b000, 0);
`ifdef PC_SEQ_BR_EN
        exp_pc = 16'h0100;
`else
        exp_pc = 16'h0014;
`endif
        checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL br_reg got %h want %h", pc_out, exp_pc); end
        do_fetch(16'hC001);
        do_exec(1, 1, COND_UNC, 9'd0, 16'h0200, 3'b000, 3'b000, 0);
        exp_pc = exp_pc + 16'd2;
        checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL br_priority got %h want %h", pc_out, exp_pc); end
    endtask

    task automatic test_stall_wait();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait%0d req=%b addr=%h valid=%b want 1 %h 0", i, imem_bus.imem_req, imem_bus.imem_addr, instr_valid, exp_pc); end
        end
        do_fetch(16'h5A5A);
        stall = 1; branch = 1; cond = COND_UNC; imm = 9'd5; flag_wr = 3'b111; flag_in = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || pc_out !== exp_pc || flags !== 3'b000 || instr_out !== 16'h5A5A) begin
                errors++; $display("FAIL stall%0d valid=%b pc=%h flags=%b instr=%h want 1 %h 000 5a5a", i, instr_valid, pc_out, flags, instr_out, exp_pc); end
        end
        stall = 0; tick(); clear_exec();
        exp_pc = exp_pc + 16'd12;
        checks++; if (pc_out !== exp_pc || flags !== 3'b101 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release pc=%h flags=%b valid=%b want %h 101 0", pc_out, flags, instr_valid, exp_pc); end
    endtask

    task automatic test_flag_update();
        do_fetch(16'hD000);
        do_exec(0, 0, 3'd0, 9'd0, 16'd0, 3'b111, 3'b000, 0);
        exp_pc = exp_pc + 16'd2;
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL flag_clear got %b want 000", flags); end
        do_fetch(16'hD001);
        do_exec(1, 0, COND_EQ, 9'h0FF, 16'd0, 3'b010, 3'b111, 0);
        exp_pc = exp_pc + 16'd2;
        checks++; if (pc_out !== exp_pc || flags !== 3'b010) begin
            errors++; $display("FAIL flag_update pc=%h flags=%b want %h 010", pc_out, flags, exp_pc); end
    endtask

    task automatic test_halt();
        do_fetch(16'hF000);
        do_exec(1, 0, COND_UNC, 9'd4, 16'd0, 3'b001, 3'b001, 1);
        checks++; if (halted !== 1'b1 || pc_out !== exp_pc || flags !== 3'b011) begin
            errors++; $display("FAIL halt_commit halted=%b pc=%h flags=%b want 1 %h 011", halted, pc_out, flags, exp_pc); end
        imem_bus.imem_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (halted !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== exp_pc) begin
                errors++; $display("FAIL halt_hold%0d halted=%b req=%b valid=%b pc=%h", i, halted, imem_bus.imem_req, instr_valid, pc_out); end
        end
        imem_bus.imem_rdy = 0;
        rst = 1; tick();
        checks++; if (pc_out !== 16'h0000 || halted !== 1'b0 || flags !== 3'b000 || instr_out !== 16'h0000) begin
            errors++; $display("FAIL halt_reset pc=%h halted=%b flags=%b instr=%h want 0000 0 000 0000", pc_out, halted, flags, instr_out); end
        rst = 0; tick(); tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0000) begin
            errors++; $display("FAIL halt_refetch req=%b addr=%h want 1 0000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_wrap();
        do_fetch(16'hE000);
        do_exec(1, 0, COND_UNC, 9'h1FE, 16'd0, 3'b000, 3'b000, 0);
        checks++; if (pc_out !== 16'hFFFE || imem_bus.imem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_back pc=%h addr=%h want fffe fffe", pc_out, imem_bus.imem_addr); end
        do_fetch(16'hE001);
        do_exec(0, 0, 3'd0, 9'd0, 16'd0, 3'b000, 3'b000, 0);
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_fwd got %h want 0000", pc_out); end
    endtask

    task automatic test_reset_abort();
        do_fetch(16'h1111);
        stall = 1; branch = 1; cond = COND_UNC; imm = 9'd8; flag_wr = 3'b111; flag_in = 3'b111;
        tick();
        rst = 1; tick(); clear_exec(); rst = 0;
        checks++; if (pc_out !== 16'h0000 || flags !== 3'b000 || instr_out !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL abort_stall pc=%h flags=%b instr=%h valid=%b", pc_out, flags, instr_out, instr_valid); end
        tick(); tick();
        imem_bus.imem_rdy = 1; imem_bus.instr_in = 16'h2222; rst = 1;
        tick();
        imem_bus.imem_rdy = 0; imem_bus.instr_in = 16'h0000; rst = 0;
        checks++; if (instr_out !== 16'h0000 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL abort_fetch instr=%h valid=%b req=%b want 0000 0 0", instr_out, instr_valid, imem_bus.imem_req); end
        tick(); tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0000) begin
            errors++; $display("FAIL abort_refetch req=%b addr=%h want 1 0000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    initial begin
        rst = 1;
        imem_bus.imem_rdy = 0;
        imem_bus.instr_in = 16'h0000;
        exp_pc = 16'h0000;
        clear_exec();
        test_reset();
        test_sequential();
        test_branch();
        test_br();
        test_stall_wait();
        test_flag_update();
        test_halt();
        test_wrap();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
